// File: rtl/spi_oled_slave.sv
// SPI receiver for an OLED controller: oversamples a mode-0 SPI link on clk and writes data bytes into a 128x8-page frame buffer.
// Build option OLED_RX_ADDR_CMD_EN enables the column/page window commands; without it data bytes write linearly 0..1023.
module spi_oled_slave (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_cs,
   input  logic       spi_sck,
   input  logic       spi_dc,
   input  logic       spi_mosi,
   output logic       recv_valid,
   output logic       recv_dc,
   output logic [7:0] recv_data,
   output logic       write_en,
   output logic [9:0] write_addr,
   output logic [7:0] write_data,
   output logic       frame_err
);

   // state  | meaning
   // IDLE   | waiting for a command or data byte
   // COL_A  | next command byte is col_start
   // COL_B  | next command byte is col_end
   // PAGE_A | next command byte is page_start
   // PAGE_B | next command byte is page_end
`ifdef OLED_RX_ADDR_CMD_EN
   typedef enum logic [2:0] {IDLE, COL_A, COL_B, PAGE_A, PAGE_B} state_t;
   state_t state;
`endif

   logic       cs_m, cs_s, sck_m, sck_s, sck_d, dc_m, dc_s, mosi_m, mosi_s;
   logic       rise_q;
   logic [6:0] shift;
   logic [2:0] bit_cnt;
   logic [6:0] col, col_start, col_end;
   logic [2:0] page, page_start, page_end;
   logic [7:0] byte_c;
   logic       byte_done;

   assign byte_c    = {shift, mosi_s};
   assign byte_done = rise_q & ~cs_s & (bit_cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_m       <= 1'b1;
         cs_s       <= 1'b1;
         sck_m      <= 1'b0;
         sck_s      <= 1'b0;
         sck_d      <= 1'b0;
         dc_m       <= 1'b0;
         dc_s       <= 1'b0;
         mosi_m     <= 1'b0;
         mosi_s     <= 1'b0;
         rise_q     <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         recv_valid <= 1'b0;
         recv_dc    <= 1'b0;
         recv_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         cs_m       <= spi_cs;
         cs_s       <= cs_m;
         sck_m      <= spi_sck;
         sck_s      <= sck_m;
         sck_d      <= sck_s;
         dc_m       <= spi_dc;
         dc_s       <= dc_m;
         mosi_m     <= spi_mosi;
         mosi_s     <= mosi_m;
         rise_q     <= sck_s & ~sck_d;
         recv_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (cs_s) begin
            // partial byte is dropped when the frame ends early
            frame_err <= (bit_cnt != 3'd0);
            bit_cnt   <= '0;
         end else if (rise_q) begin
            shift   <= byte_c[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               recv_valid <= 1'b1;
               recv_dc    <= dc_s;
               recv_data  <= byte_c;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
`ifdef OLED_RX_ADDR_CMD_EN
         state      <= IDLE;
`endif
         col        <= '0;
         page       <= '0;
         col_start  <= '0;
         col_end    <= 7'd127;
         page_start <= '0;
         page_end   <= 3'd7;
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
      end else begin
         write_en <= 1'b0;
         if (byte_done && dc_s) begin
            write_en   <= 1'b1;
            write_addr <= {page, col};
            write_data <= byte_c;
            // wrap only on equality so inverted windows pass through 127 -> 0
            if (col == col_end) begin
               col  <= col_start;
               page <= (page == page_end) ? page_start : page + 3'd1;
            end else begin
               col <= col + 7'd1;
            end
`ifdef OLED_RX_ADDR_CMD_EN
            state <= IDLE;
`endif
         end
`ifdef OLED_RX_ADDR_CMD_EN
         else if (byte_done) begin
            case (state)
               IDLE: begin
                  if (byte_c == 8'h21)
                     state <= COL_A;
                  else if (byte_c == 8'h22)
                     state <= PAGE_A;
                  else if (byte_c[7:3] == 5'b10110)
                     page <= byte_c[2:0];
               end
               COL_A: begin
                  col_start <= byte_c[6:0];
                  state     <= COL_B;
               end
               COL_B: begin
                  col_end <= byte_c[6:0];
                  col     <= col_start;
                  state   <= IDLE;
               end
               PAGE_A: begin
                  page_start <= byte_c[2:0];
                  state      <= PAGE_B;
               end
               PAGE_B: begin
                  page_end <= byte_c[2:0];
                  page     <= page_start;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
`endif
      end
   end

endmodule
